// File: rtl/para_link_pkg.sv
// Shared definitions for the parameter byte-stream link (transmit and receive ends):
// type codes, payload lengths, the largest payload and the receiver state encoding.
package para_link_pkg;

  localparam logic [7:0] PARA_DS_SYNC  = 8'h20;
  localparam logic [7:0] PARA_MS_LS    = 8'h21;
  localparam logic [7:0] PARA_DS_STAT  = 8'h22;
  localparam logic [7:0] PARA_US_STAT  = 8'h23;
  localparam logic [7:0] PARA_US_CACHE = 8'h24;
  localparam logic [7:0] PARA_SW_INFO  = 8'h30;

  localparam int PARA_DS_SYNC_LEN  = 13;
  localparam int PARA_MS_LS_LEN    = 5;
  localparam int PARA_DS_STAT_LEN  = 44;
  localparam int PARA_US_STAT_LEN  = 52;
  localparam int PARA_US_CACHE_LEN = 6;
  localparam int PARA_SW_INFO_LEN  = 4;

  localparam int PARA_MAX_BYTES = 52;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DROP  = 2'd3
  } para_state_e;

  // Payload length in bytes for a type code; 0 marks an unknown type.
  function automatic int para_len(input logic [7:0] t);
    int len;
    case (t)
      PARA_DS_SYNC:  len = PARA_DS_SYNC_LEN;
      PARA_MS_LS:    len = PARA_MS_LS_LEN;
      PARA_DS_STAT:  len = PARA_DS_STAT_LEN;
      PARA_US_STAT:  len = PARA_US_STAT_LEN;
      PARA_US_CACHE: len = PARA_US_CACHE_LEN;
      PARA_SW_INFO:  len = PARA_SW_INFO_LEN;
      default:       len = 0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/para_len_lut.sv
// Combinational type-code -> {payload length, type valid} lookup, shared by the
// parameter link transmitter and receiver.
module para_len_lut
  import para_link_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic [7:0]       i_type,
  output logic [LEN_W-1:0] o_len,
  output logic             o_valid
);

  int w_len;

  always_comb begin
    w_len   = para_len(i_type);
    o_len   = LEN_W'(w_len);
    o_valid = (w_len != 0);
  end

endmodule

// File: rtl/para_frame_rx.sv
// Parameter link receiver: reassembles MSB-first byte bursts into per-type status
// registers and length-checks each frame. Optional trailing XOR check byte: PARA_RX_XOR_CHK_EN.
module para_frame_rx
  import para_link_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int MAX_BYTES = PARA_MAX_BYTES
) (
  input  logic         sys_clk_i,
  input  logic         rst_n_i,
  input  logic [7:0]   i_para_type,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic [103:0] ds_sync_data_o,
  output logic [39:0]  ms_ls_status_o,
  output logic [351:0] ds_statistics_o,
  output logic [415:0] us_statistics_o,
  output logic [47:0]  us_data_cache_cnt_o,
  output logic [31:0]  software_info_o,
  output logic         o_update,
  output logic [7:0]   o_update_type,
  output logic         o_len_err,
  output logic [15:0]  o_frame_cnt
);

`ifdef PARA_RX_XOR_CHK_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  // Payload sits above the check byte when the check byte is present.
  localparam int ACC_BYTES = MAX_BYTES + CHK_BYTES;
  localparam int ACC_W     = 8 * ACC_BYTES;
  localparam int PAY_OFF   = 8 * CHK_BYTES;
  localparam logic [CNT_W-1:0] ACC_CNT = CNT_W'(ACC_BYTES);

  para_state_e        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_type;
  logic               r_update;
  logic               r_len_err;
  logic [7:0]         r_update_type;
  logic [15:0]        r_frame_cnt;
  logic [103:0]       r_ds_sync;
  logic [39:0]        r_ms_ls;
  logic [351:0]       r_ds_stat;
  logic [415:0]       r_us_stat;
  logic [47:0]        r_us_cache;
  logic [31:0]        r_sw_info;

  logic [CNT_W-1:0]   w_len;
  logic               w_type_ok;
  logic [CNT_W-1:0]   w_exp_len;
  logic               w_xor_ok;
  logic               w_accept;
  logic [ACC_W-1:0]   w_acc_shift;

  para_len_lut #(
    .LEN_W (CNT_W)
  ) u_len_lut (
    .i_type  (r_type),
    .o_len   (w_len),
    .o_valid (w_type_ok)
  );

`ifdef PARA_RX_XOR_CHK_EN
  // Running XOR over payload and check byte; a good frame folds to zero.
  logic [7:0] r_xor;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_xor <= 8'h00;
    end else if (rx_valid_i) begin
      if (r_state == ST_IDLE) begin
        r_xor <= rx_data_i;
      end else if ((r_state == ST_RECV) && (r_cnt != ACC_CNT)) begin
        r_xor <= r_xor ^ rx_data_i;
      end
    end
  end

  assign w_xor_ok = (r_xor == 8'h00);
`else
  assign w_xor_ok = 1'b1;
`endif

  assign w_exp_len   = w_len + CNT_W'(CHK_BYTES);
  assign w_accept    = w_type_ok && (r_cnt == w_exp_len) && w_xor_ok;
  assign w_acc_shift = {r_acc[ACC_W-9:0], rx_data_i};

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_type        <= 8'h00;
      r_update      <= 1'b0;
      r_len_err     <= 1'b0;
      r_update_type <= 8'h00;
      r_frame_cnt   <= 16'h0000;
      r_ds_sync     <= '0;
      r_ms_ls       <= '0;
      r_ds_stat     <= '0;
      r_us_stat     <= '0;
      r_us_cache    <= '0;
      r_sw_info     <= '0;
    end else begin
      r_update  <= 1'b0;
      r_len_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid_i) begin
            r_type  <= i_para_type;
            r_acc   <= w_acc_shift;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (!rx_valid_i) begin
            r_state <= ST_CHECK;
          end else if (r_cnt == ACC_CNT) begin
            r_state <= ST_DROP;
          end else begin
            r_acc <= w_acc_shift;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (w_accept) begin
            r_update      <= 1'b1;
            r_update_type <= r_type;
            r_frame_cnt   <= r_frame_cnt + 16'd1;
            case (r_type)
              PARA_DS_SYNC:  r_ds_sync  <= r_acc[PAY_OFF +: 104];
              PARA_MS_LS:    r_ms_ls    <= r_acc[PAY_OFF +: 40];
              PARA_DS_STAT:  r_ds_stat  <= r_acc[PAY_OFF +: 352];
              PARA_US_STAT:  r_us_stat  <= r_acc[PAY_OFF +: 416];
              PARA_US_CACHE: r_us_cache <= r_acc[PAY_OFF +: 48];
              PARA_SW_INFO:  r_sw_info  <= r_acc[PAY_OFF +: 32];
              default: ;
            endcase
          end else begin
            r_len_err <= 1'b1;
          end
          // A byte arriving here starts a burst too early; it is thrown away whole.
          r_state <= rx_valid_i ? ST_DROP : ST_IDLE;
        end
        ST_DROP: begin
          if (!rx_valid_i) begin
            r_len_err <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ds_sync_data_o      = r_ds_sync;
  assign ms_ls_status_o      = r_ms_ls;
  assign ds_statistics_o     = r_ds_stat;
  assign us_statistics_o     = r_us_stat;
  assign us_data_cache_cnt_o = r_us_cache;
  assign software_info_o     = r_sw_info;
  assign o_update            = r_update;
  assign o_update_type       = r_update_type;
  assign o_len_err           = r_len_err;
  assign o_frame_cnt         = r_frame_cnt;

endmodule

// File: tb/tb_para_frame_rx.sv
// Scoreboard bench for para_frame_rx: directed bursts then random bursts, each burst's
// expected outcome is queued at issue and checked when the DUT strobes.
module tb_para_frame_rx;

`ifdef PARA_RX_XOR_CHK_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif
  localparam int ACC_BYTES = 52 + XB;

  logic         sys_clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic [7:0]   i_para_type = 8'h00;
  logic [7:0]   rx_data_i = 8'h00;
  logic         rx_valid_i = 1'b0;
  logic [103:0] ds_sync_data_o;
  logic [39:0]  ms_ls_status_o;
  logic [351:0] ds_statistics_o;
  logic [415:0] us_statistics_o;
  logic [47:0]  us_data_cache_cnt_o;
  logic [31:0]  software_info_o;
  logic         o_update;
  logic [7:0]   o_update_type;
  logic         o_len_err;
  logic [15:0]  o_frame_cnt;

  para_frame_rx dut (
    .sys_clk_i           (sys_clk_i),
    .rst_n_i             (rst_n_i),
    .i_para_type         (i_para_type),
    .rx_data_i           (rx_data_i),
    .rx_valid_i          (rx_valid_i),
    .ds_sync_data_o      (ds_sync_data_o),
    .ms_ls_status_o      (ms_ls_status_o),
    .ds_statistics_o     (ds_statistics_o),
    .us_statistics_o     (us_statistics_o),
    .us_data_cache_cnt_o (us_data_cache_cnt_o),
    .software_info_o     (software_info_o),
    .o_update            (o_update),
    .o_update_type       (o_update_type),
    .o_len_err           (o_len_err),
    .o_frame_cnt         (o_frame_cnt)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    bit           is_upd;
    logic [7:0]   typ;
    logic [15:0]  fcnt;
    logic [103:0] r20;
    logic [39:0]  r21;
    logic [351:0] r22;
    logic [415:0] r23;
    logic [47:0]  r24;
    logic [31:0]  r30;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;

  // Reference model state: what the registers should hold, and link history.
  logic [103:0] m20;
  logic [39:0]  m21;
  logic [351:0] m22;
  logic [415:0] m23;
  logic [47:0]  m24;
  logic [31:0]  m30;
  logic [7:0]   m_type;
  logic [15:0]  m_fcnt;
  bit           prev_checked;
  logic [7:0]   pay[0:63];

  function automatic int tbl_len(input logic [7:0] t);
    case (t)
      8'h20: return 13;
      8'h21: return 5;
      8'h22: return 44;
      8'h23: return 52;
      8'h24: return 6;
      8'h30: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [415:0] act, input logic [415:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m20 = '0; m21 = '0; m22 = '0; m23 = '0; m24 = '0; m30 = '0;
    m_type = 8'h00; m_fcnt = 16'h0000; prev_checked = 1'b0;
  endtask

  task automatic push_event(input bit upd);
    exp_t e;
    e.is_upd = upd; e.typ = m_type; e.fcnt = m_fcnt;
    e.r20 = m20; e.r21 = m21; e.r22 = m22; e.r23 = m23; e.r24 = m24; e.r30 = m30;
    q.push_back(e);
  endtask

  // Send pay[0..len-1] (plus check byte when enabled) after 'gap' idle cycles.
  task automatic send_burst(input logic [7:0] t, input int len, input int gap, input bit bad_xor);
    logic [7:0]   x;
    logic [415:0] v;
    int           total;
    x = 8'h00;
    v = '0;
    for (int i = 0; i < len; i++) begin
      x ^= pay[i];
      v = {v[407:0], pay[i]};
    end
    if (bad_xor) x ^= 8'h5A;
    pay[len] = x;
    total = len + XB;
    if (prev_checked && gap == 1) begin
      push_event(1'b0);
      prev_checked = 1'b0;
    end else if (total > ACC_BYTES) begin
      push_event(1'b0);
      prev_checked = 1'b0;
    end else begin
      if (tbl_len(t) != 0 && len == tbl_len(t) && !(XB == 1 && bad_xor)) begin
        case (t)
          8'h20: m20 = v[103:0];
          8'h21: m21 = v[39:0];
          8'h22: m22 = v[351:0];
          8'h23: m23 = v;
          8'h24: m24 = v[47:0];
          default: m30 = v[31:0];
        endcase
        m_type = t;
        m_fcnt = m_fcnt + 16'd1;
        push_event(1'b1);
      end else begin
        push_event(1'b0);
      end
      prev_checked = 1'b1;
    end
    repeat (gap) begin
      @(negedge sys_clk_i);
      rx_valid_i = 1'b0;
      i_para_type = 8'($urandom);
    end
    for (int i = 0; i < total; i++) begin
      @(negedge sys_clk_i);
      rx_valid_i  = 1'b1;
      rx_data_i   = pay[i];
      i_para_type = (i == 0) ? t : 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    @(negedge sys_clk_i);
    rx_valid_i = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge sys_clk_i);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending events", q.size());
      q.delete();
    end
    prev_checked = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ds_sync"}, 416'(ds_sync_data_o), '0);
    chk({tag, "_ms_ls"}, 416'(ms_ls_status_o), '0);
    chk({tag, "_ds_stat"}, 416'(ds_statistics_o), '0);
    chk({tag, "_us_stat"}, us_statistics_o, '0);
    chk({tag, "_us_cache"}, 416'(us_data_cache_cnt_o), '0);
    chk({tag, "_sw_info"}, 416'(software_info_o), '0);
    chk({tag, "_update"}, 416'(o_update), '0);
    chk({tag, "_upd_type"}, 416'(o_update_type), '0);
    chk({tag, "_len_err"}, 416'(o_len_err), '0);
    chk({tag, "_frame_cnt"}, 416'(o_frame_cnt), '0);
  endtask

  // Monitor: every strobe consumes one expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk_i);
      if (rst_n_i && (o_update || o_len_err)) begin
        chk("strobe_exclusive", 416'(o_update & o_len_err), '0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual=update:%0b,len_err:%0b required=none", o_update, o_len_err);
        end else begin
          e = q.pop_front();
          $display("event: upd=%0b type=%02h fcnt=%0d", o_update, o_update_type, o_frame_cnt);
          chk("update", 416'(o_update), 416'(e.is_upd));
          chk("len_err", 416'(o_len_err), 416'(!e.is_upd));
          chk("update_type", 416'(o_update_type), 416'(e.typ));
          chk("frame_cnt", 416'(o_frame_cnt), 416'(e.fcnt));
          chk("ds_sync", 416'(ds_sync_data_o), 416'(e.r20));
          chk("ms_ls", 416'(ms_ls_status_o), 416'(e.r21));
          chk("ds_stat", 416'(ds_statistics_o), 416'(e.r22));
          chk("us_stat", us_statistics_o, e.r23);
          chk("us_cache", 416'(us_data_cache_cnt_o), 416'(e.r24));
          chk("sw_info", 416'(software_info_o), 416'(e.r30));
        end
      end
    end
  end

  initial begin
    logic [7:0] t;
    int len, gap;
    model_reset();
    repeat (3) @(negedge sys_clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    repeat (2) @(negedge sys_clk_i);

    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h11 * (i + 1));
    send_burst(8'h21, 5, 2, 1'b0);
    drain();

    for (int i = 0; i < 52; i++) pay[i] = 8'(i);
    send_burst(8'h23, 52, 2, 1'b0);
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    send_burst(8'h24, 5, 2, 1'b0);
    drain();

    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    send_burst(8'h0A, 3, 2, 1'b0);
    drain();

    for (int i = 0; i < 60; i++) pay[i] = 8'($urandom);
    send_burst(8'h22, 60, 2, 1'b0);
    drain();

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
      send_burst(8'h30, 4, (k == 1) ? 1 : 2, 1'b0);
    end
    drain();

    // Reset mid-frame: three bytes of a 0x20 frame, then pulse reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk_i);
      rx_valid_i = 1'b1; rx_data_i = 8'($urandom); i_para_type = 8'h20;
    end
    @(negedge sys_clk_i);
    rst_n_i = 1'b0; rx_valid_i = 1'b0;
    @(negedge sys_clk_i);
    check_all_zero("midrst");
    model_reset();
    rst_n_i = 1'b1;
    for (int i = 0; i < 13; i++) pay[i] = 8'($urandom);
    send_burst(8'h20, 13, 2, 1'b0);
    drain();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0: t = 8'h20;
        1: t = 8'h21;
        2: t = 8'h22;
        3: t = 8'h23;
        4: t = 8'h24;
        5: t = 8'h30;
        default: t = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0)
        len = (tbl_len(t) != 0) ? tbl_len(t) : int'($urandom_range(1, 8));
      else
        len = $urandom_range(1, 60);
      gap = ($urandom_range(0, 4) == 0) ? 1 : int'($urandom_range(2, 4));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      send_burst(t, len, gap, ($urandom_range(0, 7) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
